// File: rtl/uart_mmio_bridge.sv
// MMIO slave bridging the CPU load/store port to the UART core: status, RX FIFO,
// TX holding register and a free-running cycle counter in one 256-byte window.
module uart_mmio_bridge #(
    parameter int          RxDepth    = 8,
    parameter int          RxAddrBits = 3,
    parameter logic [31:0] IoBase     = 32'h8000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    input  logic        WrEn,
    input  logic        RdEn,
    output logic [31:0] RdData,
    output logic [7:0]  UartDataIn,
    output logic        UartDataInValid,
    input  logic        UartDataInReady,
    input  logic [7:0]  UartDataOut,
    input  logic        UartDataOutValid,
    output logic        UartDataOutReady
);

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_BUSY = 1'b1;

    localparam logic [5:0] REG_STATUS = 6'h00;
    localparam logic [5:0] REG_RXDATA = 6'h01;
    localparam logic [5:0] REG_TXDATA = 6'h02;
    localparam logic [5:0] REG_CYCLES = 6'h04;

    logic [31:0]           rd_data_q, rd_data_d;
    logic [0:0]            tx_state_q, tx_state_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [31:0]           cyc_q, cyc_d;
    logic [RxAddrBits-1:0] rx_wptr_q, rx_wptr_d;
    logic [RxAddrBits-1:0] rx_rptr_q, rx_rptr_d;
    logic [RxAddrBits:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]            rx_mem_q [RxDepth];

    logic       access, rd_acc, wr_acc;
    logic [5:0] reg_sel;
    logic       rx_empty, rx_full, rx_push, rx_pop;
    logic       tx_ready;
    logic       unused_ok;

    assign unused_ok = ^{WrData[31:8], Addr[1:0]};

    assign access  = (RdEn | WrEn) & ~Stall & (Addr[31:8] == IoBase[31:8]);
    assign rd_acc  = access & RdEn;
    assign wr_acc  = access & WrEn;
    assign reg_sel = Addr[7:2];

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == (RxAddrBits+1)'(RxDepth));
    assign rx_push  = UartDataOutValid & ~rx_full;
    assign rx_pop   = rd_acc & (reg_sel == REG_RXDATA) & ~rx_empty;

    assign tx_ready = (tx_state_q == TX_IDLE) & UartDataInReady;

    assign RdData           = rd_data_q;
    assign UartDataIn       = tx_data_q;
    assign UartDataInValid  = (tx_state_q == TX_BUSY);
    assign UartDataOutReady = ~rx_full;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            case (reg_sel)
                REG_STATUS: rd_data_d = {30'b0, ~rx_empty, tx_ready};
                REG_RXDATA: rd_data_d = rx_empty ? 32'h0 : {24'b0, rx_mem_q[rx_rptr_q]};
                REG_CYCLES: rd_data_d = cyc_q;
                default:    rd_data_d = 32'h0;
            endcase
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_acc && reg_sel == REG_TXDATA && tx_ready) begin
                    tx_data_d  = WrData[7:0];
                    tx_state_d = TX_BUSY;
                end
            end
            default: begin
                if (UartDataInReady) tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Write to the counter wins over the increment on the same edge.
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (wr_acc && reg_sel == REG_CYCLES) cyc_d = 32'h0;
    end

    always_comb begin
        rx_wptr_d = rx_push ? rx_wptr_q + RxAddrBits'(1) : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + RxAddrBits'(1) : rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (RxAddrBits+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (RxAddrBits+1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rd_data_q  <= 32'h0;
            tx_state_q <= TX_IDLE;
            tx_data_q  <= 8'h0;
            cyc_q      <= 32'h0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            cyc_q      <= cyc_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

    // Storage needs no reset; only entries below the count are ever read.
    always_ff @(posedge Clock) begin
        if (Reset && rx_push) rx_mem_q[rx_wptr_q] <= UartDataOut;
    end

endmodule
